// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: bit timing at 100 MHz, frame length, genMode encodings and the
// bit-generator state encoding used by the bit generator, control FSM and RET counter.
package ws2812_pkg;

  localparam int unsigned T0hCycles = 40;
  localparam int unsigned T0lCycles = 85;
  localparam int unsigned T1hCycles = 80;
  localparam int unsigned T1lCycles = 45;
  localparam int unsigned NumBits   = 96;

  localparam int unsigned PhaseW = 7;
  localparam int unsigned CountW = 7;

  localparam logic [1:0] GenIdle = 2'b00;
  localparam logic [1:0] GenRsvd = 2'b01;
  localparam logic [1:0] GenZero = 2'b10;
  localparam logic [1:0] GenOne  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } ws_state_e;

  // Only 10 and 11 request a bit; 00 and the reserved 01 both mean idle.
  function automatic logic gen_active(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/ws_bit_gen.sv
// WS2812B bit generator: shapes each requested bit into a fixed-length high/low period and
// counts bits until a full frame has been sent.
module ws_bit_gen
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H      = T0hCycles,
  parameter int unsigned T0L      = T0lCycles,
  parameter int unsigned T1H      = T1hCycles,
  parameter int unsigned T1L      = T1lCycles,
  parameter int unsigned NUM_BITS = NumBits
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       doGen,
  input  logic [1:0] genMode,
  output logic       dout,
  output logic       bitDone,
  output logic       sendDone
);

  localparam logic [PhaseW-1:0] T0hLd   = PhaseW'(T0H - 1);
  localparam logic [PhaseW-1:0] T0lLd   = PhaseW'(T0L - 1);
  localparam logic [PhaseW-1:0] T1hLd   = PhaseW'(T1H - 1);
  localparam logic [PhaseW-1:0] T1lLd   = PhaseW'(T1L - 1);
  localparam logic [CountW-1:0] LastBit = CountW'(NUM_BITS - 1);

  ws_state_e         state;
  logic [PhaseW-1:0] phase;
  logic [CountW-1:0] bit_cnt;
  logic              bit_val;

  logic              start_ok;
  logic [PhaseW-1:0] high_ld;
  logic [PhaseW-1:0] low_ld;

  always_comb begin
    start_ok = doGen && gen_active(genMode);
    high_ld  = genMode[0] ? T1hLd : T0hLd;
    low_ld   = bit_val ? T1lLd : T0lLd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      phase    <= '0;
      bit_cnt  <= '0;
      bit_val  <= 1'b0;
      dout     <= 1'b0;
      bitDone  <= 1'b0;
      sendDone <= 1'b0;
    end else begin
      bitDone <= 1'b0;
      unique case (state)
        StIdle: begin
          dout <= 1'b0;
          if (start_ok && !sendDone) begin
            state   <= StHigh;
            dout    <= 1'b1;
            bit_val <= genMode[0];
            phase   <= high_ld;
          end
        end

        StHigh: begin
          if (!doGen) begin
            state   <= StIdle;
            dout    <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
          end else if (phase == '0) begin
            state   <= StLow;
            dout    <= 1'b0;
            phase   <= low_ld;
            // A one-cycle low phase would make its first cycle the final one.
            bitDone <= (low_ld == '0);
          end else begin
            phase <= phase - PhaseW'(1);
          end
        end

        StLow: begin
          if (!doGen) begin
            state   <= StIdle;
            dout    <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
          end else if (phase == '0) begin
            bit_cnt <= bit_cnt + CountW'(1);
            if (bit_cnt == LastBit) begin
              state    <= StDone;
              dout     <= 1'b0;
              sendDone <= 1'b1;
              phase    <= '0;
            end else if (start_ok) begin
              // Back-to-back bits: no gap cycle, so the period stays exactly high+low.
              state   <= StHigh;
              dout    <= 1'b1;
              bit_val <= genMode[0];
              phase   <= high_ld;
            end else begin
              state <= StIdle;
              dout  <= 1'b0;
              phase <= '0;
            end
          end else begin
            phase <= phase - PhaseW'(1);
            if (phase == PhaseW'(1)) begin
              bitDone <= 1'b1;
            end
          end
        end

        StDone: begin
          dout <= 1'b0;
          if (!doGen) begin
            state    <= StIdle;
            sendDone <= 1'b0;
            bit_cnt  <= '0;
            phase    <= '0;
          end
        end

        default: begin
          state <= StIdle;
          dout  <= 1'b0;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_bit_gen.sv
// Randomized and directed bench for ws_bit_gen against a time-in-bit reference model.
module tb_ws_bit_gen;

  localparam int unsigned HiZero  = 40;
  localparam int unsigned HiOne   = 80;
  localparam int unsigned Period  = 125;
  localparam int unsigned FrameN  = 96;
  localparam int unsigned FrameTo = 13000;

  logic       clk;
  logic       reset;
  logic       do_gen;
  logic [1:0] gen_mode;
  logic       dout;
  logic       bit_done;
  logic       send_done;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_bd;

  // Reference model: whether a bit is in flight, how long it has run, and frame progress.
  logic        m_act;
  int unsigned m_t;
  logic        m_val;
  int unsigned m_cnt;
  logic        m_done;

  ws_bit_gen dut (
    .clk      (clk),
    .reset    (reset),
    .doGen    (do_gen),
    .genMode  (gen_mode),
    .dout     (dout),
    .bitDone  (bit_done),
    .sendDone (send_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned high_len(input logic v);
    return v ? HiOne : HiZero;
  endfunction

  task automatic model_step(input logic dg, input logic [1:0] gm, input logic rs);
    if (rs) begin
      m_act = 1'b0; m_t = 0; m_val = 1'b0; m_cnt = 0; m_done = 1'b0;
    end else if (m_done) begin
      if (!dg) begin
        m_done = 1'b0;
        m_cnt  = 0;
      end
    end else if (m_act) begin
      if (!dg) begin
        m_act = 1'b0;
        m_cnt = 0;
      end else if (m_t == Period - 1) begin
        m_cnt++;
        if (m_cnt == FrameN) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end else if (gm[1]) begin
          m_t   = 0;
          m_val = gm[0];
        end else begin
          m_act = 1'b0;
        end
      end else begin
        m_t++;
      end
    end else if (dg && gm[1]) begin
      m_act = 1'b1;
      m_t   = 0;
      m_val = gm[0];
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic tick(input logic dg, input logic [1:0] gm, input logic rs);
    do_gen   = dg;
    gen_mode = gm;
    reset    = rs;
    @(posedge clk);
    model_step(dg, gm, rs);
    @(negedge clk);
    check_eq("dout", dout, (m_act && m_t < high_len(m_val)) ? 1 : 0);
    check_eq("bit_done", bit_done, (m_act && m_t == Period - 1) ? 1 : 0);
    check_eq("send_done", send_done, m_done ? 1 : 0);
    if (bit_done) n_bd++;
  endtask

  task automatic run_frame(input logic rand_bits, input logic fixed_bit, output int unsigned bits);
    int unsigned bd0;
    int unsigned cyc;
    logic        b;
    bd0 = n_bd;
    cyc = 0;
    while (!send_done && cyc < FrameTo) begin
      b = rand_bits ? 1'($urandom % 2) : fixed_bit;
      tick(1'b1, {1'b1, b}, 1'b0);
      cyc++;
    end
    check_eq("frame_done", send_done, 1);
    bits = n_bd - bd0;
  endtask

  initial begin
    int unsigned bits;
    int unsigned bd0;
    int unsigned highs;
    int unsigned highs2;
    int unsigned cyc;
    logic        dg;
    logic        rs;

    n_checks = 0; n_fail = 0; n_bd = 0;
    m_act = 1'b0; m_t = 0; m_val = 1'b0; m_cnt = 0; m_done = 1'b0;

    repeat (3) tick(1'b0, 2'b00, 1'b1);
    check_eq("reset_dout", dout, 0);
    check_eq("reset_send_done", send_done, 0);
    tick(1'b0, 2'b00, 1'b0);

    // Zero bits held: 40 high, 85 low, bitDone at 125, next bit at 126.
    for (int k = 1; k <= 260; k++) begin
      tick(1'b1, 2'b10, 1'b0);
      if (k == 1)   check_eq("t0_first_high", dout, 1);
      if (k == 40)  check_eq("t0_last_high", dout, 1);
      if (k == 41)  check_eq("t0_first_low", dout, 0);
      if (k == 124) check_eq("t0_no_early_done", bit_done, 0);
      if (k == 125) check_eq("t0_bit_done", bit_done, 1);
      if (k == 126) check_eq("t0_next_bit", dout, 1);
    end
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);

    // Full frame of ones, then hold doGen in DONE and release.
    run_frame(1'b0, 1'b1, bits);
    check_eq("ones_frame_bits", bits, FrameN);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 2'b11, 1'b0);
      highs += dout;
    end
    check_eq("done_dout_low", highs, 0);
    check_eq("done_held", send_done, 1);
    tick(1'b0, 2'b11, 1'b0);
    check_eq("done_clear", send_done, 0);
    tick(1'b0, 2'b00, 1'b0);

    // genMode[0] flips 20 cycles into a 1 bit; only the following bit sees it.
    highs = 0; highs2 = 0;
    for (int k = 1; k <= 250; k++) begin
      tick(1'b1, (k < 20) ? 2'b11 : 2'b10, 1'b0);
      if (k <= 125) highs += dout;
      else highs2 += dout;
    end
    check_eq("latched_bit_width", highs, HiOne);
    check_eq("next_bit_width", highs2, HiZero);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);

    // Abort at cycle 60 of a 1 bit.
    bd0 = n_bd;
    for (int k = 1; k < 60; k++) tick(1'b1, 2'b11, 1'b0);
    tick(1'b0, 2'b11, 1'b0);
    check_eq("abort_dout", dout, 0);
    repeat (130) tick(1'b0, 2'b11, 1'b0);
    check_eq("abort_no_bit_done", n_bd - bd0, 0);
    run_frame(1'b1, 1'b0, bits);
    check_eq("after_abort_bits", bits, FrameN);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);

    // Reset during the low phase of bit 50.
    bd0 = n_bd;
    cyc = 0;
    while (n_bd - bd0 < 49 && cyc < FrameTo) begin
      tick(1'b1, {1'b1, 1'($urandom % 2)}, 1'b0);
      cyc++;
    end
    check_eq("reached_bit_50", n_bd - bd0, 49);
    repeat (100) tick(1'b1, {1'b1, 1'($urandom % 2)}, 1'b0);
    tick(1'b1, 2'b11, 1'b1);
    check_eq("midbit_reset_dout", dout, 0);
    check_eq("midbit_reset_bit_done", bit_done, 0);
    check_eq("midbit_reset_send_done", send_done, 0);
    tick(1'b0, 2'b00, 1'b0);
    run_frame(1'b1, 1'b0, bits);
    check_eq("after_reset_bits", bits, FrameN);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);

    // Reserved genMode keeps the line idle.
    bd0 = n_bd;
    highs = 0;
    repeat (200) begin
      tick(1'b1, 2'b01, 1'b0);
      highs += dout;
    end
    check_eq("rsvd_dout", highs, 0);
    check_eq("rsvd_bit_done", n_bd - bd0, 0);
    tick(1'b0, 2'b00, 1'b0);

    // Random traffic: mostly-held doGen, random modes, rare resets.
    for (int k = 0; k < 6000; k++) begin
      dg = ($urandom_range(0, 199) != 0);
      rs = ($urandom_range(0, 2999) == 0);
      tick(dg, 2'($urandom), rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ws_bit_gen.md
WS_BIT_GEN -- requirements
Module: ws_bit_gen

Interface
REQ-001 Parameters: T0H=40 (cycles high for a 0 bit), T0L=85 (cycles low for a 0 bit), T1H=80 (cycles high for a 1 bit), T1L=45 (cycles low for a 1 bit), NUM_BITS=96 (bits per frame); all sized for 100 MHz clk.
REQ-002 clk  input  1  system clock, all logic on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 doGen  input  1  frame-send enable from the control FSM; level.
REQ-005 genMode  input  2  00 = idle/low, 10 = send 0, 11 = send 1, 01 = reserved (treated as 00).
REQ-006 dout  output  1  registered WS2812B serial data line.
REQ-007 bitDone  output  1  one-cycle pulse on the last low cycle of every completed bit; the shift register advances on it.
REQ-008 sendDone  output  1  level; high once NUM_BITS bits are complete in the current frame.

Function
REQ-009 FSM states IDLE, HIGH, LOW, DONE; state, dout, bitDone and sendDone SHALL all be registered.
REQ-010 IDLE: dout=0. Go to HIGH when doGen=1, genMode[1]=1 and sendDone=0. Latch genMode[0] as the bit value at that edge.
REQ-011 HIGH: dout=1 for exactly T1H cycles if the latched bit is 1, else T0H cycles; then go to LOW.
REQ-012 LOW: dout=0 for exactly T1L or T0L cycles; bitDone=1 on the final LOW cycle only; the bit counter increments on that cycle.
REQ-013 After the final LOW cycle: if the counter reaches NUM_BITS, go to DONE; else if doGen=1 and genMode[1]=1, go straight to HIGH with no gap cycle, latching the new genMode[0]; else go to IDLE.
REQ-014 Every bit period SHALL be exactly 125 cycles, independent of bit value.
REQ-015 DONE: dout=0 and sendDone=1; stay in DONE while doGen=1; go to IDLE and clear sendDone and the bit counter on the first cycle doGen=0.
REQ-016 The bit value is sampled only at entry to HIGH; genMode changes during a bit have no effect on that bit.
REQ-017 Latency: dout rises on the first clk edge after doGen/genMode qualify in IDLE.
REQ-018 If doGen drops in HIGH or LOW: abort the bit, dout=0 on the next cycle, no bitDone, clear the counter, go to IDLE.
REQ-019 genMode=00 or 01 with doGen=1 in IDLE: remain in IDLE, dout=0.
REQ-020 Bit counter width SHALL be 7 bits; it never exceeds NUM_BITS and never wraps.
REQ-021 A single phase counter SHALL count down from phase length minus 1 to 0, 7 bits wide, and reload on each state change.

Reset
REQ-022 On reset: state=IDLE, dout=0, bitDone=0, sendDone=0, bit counter=0, phase counter=0, latched bit=0.
REQ-023 Reset SHALL take priority over every other input, including mid-bit and in DONE.

Structure
REQ-024 Timing constants, NUM_BITS, genMode encodings and the FSM state encoding SHALL live in the shared ws2812 package, used also by the control FSM and the RET counter.
REQ-025 No sub-module is needed; the phase counter and bit counter stay inline in one module.

Verification
REQ-026 Reset, then doGen=1, genMode=10 held: dout high 40 cycles, low 85 cycles, bitDone pulse at cycle 125, next bit starts at cycle 126.
REQ-027 genMode=11 held for a full frame: 96 bitDone pulses, each bit 80 high / 45 low; sendDone rises after the 96th bitDone; dout stays 0 while doGen=1; sendDone clears one cycle after doGen=0.
REQ-028 Alternate genMode[0] mid-bit, at cycle 20 of the high phase: the current bit keeps its latched width; the new value applies to the next bit only.
REQ-029 Drop doGen at cycle 60 of a 1 bit: dout=0 on the next cycle, no bitDone, bit counter=0; the next doGen frame again yields 96 bits.
REQ-030 Assert reset during LOW of bit 50: all outputs 0 the next cycle; the following frame completes 96 bits.
REQ-031 doGen=1 with genMode=01: dout stays 0 and no bitDone for 200 cycles.
